comp_pipe_nbit: RTL and testbench
=================================

# comp_pipe_nbit

Parametrised, pipelined magnitude comparator with valid/ready flow control and a per-transaction compare mode: unsigned, two's-complement signed, or IEEE-754-style sign-magnitude. It generalises the fixed 8-bit less-than tree to DATA_W bits and adds equal, greater and unordered results. It serves as the shared compare engine for the FP datapath (exponent alignment select, FP compare/min/max), sitting between operand registers and the result mux.

## Interface
- DATA_W, 32: operand width; a multiple of LEAF_W, minimum 8.
- LEAF_W, 4: width of each first-level leaf compare.
- EXP_W, 8: exponent field width used in FP mode, with the sign at bit DATA_W-1 and the exponent at [DATA_W-2 -: EXP_W]. Mantissa width is MAN_W = DATA_W-1-EXP_W.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block can accept input this cycle.
- i_data_a  in  DATA_W  operand A.
- i_data_b  in  DATA_W  operand B.
- i_mode  in  2  compare mode: 00 unsigned, 01 signed, 10 FP, 11 reserved (treated as unsigned).
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_less  out  1  A < B.
- o_equal  out  1  A == B.
- o_greater  out  1  A > B.
- o_unord  out  1  FP mode only: A or B is NaN.

## Operation
- Two register stages, S1 and S2, each with its own valid bit.
- S1 captures the following on an accepted input (i_valid & o_ready):
  - per-leaf less/equal vectors, N_LEAF = DATA_W/LEAF_W;
  - the mode;
  - sign_a and sign_b;
  - mag_zero_a and mag_zero_b (bits [DATA_W-2:0] all zero);
  - nan_a and nan_b (exponent all ones and mantissa non-zero).
- Signed mode: both operand MSBs are inverted before the leaf compares, so the unsigned tree result is the signed result.
- S2 reduces the leaf vectors high to low, as a Less = L_hi | (E_hi & L_lo) tree, into less_u and eq_u.
- S2 then applies the mode:
  - Unsigned / signed / reserved: less = less_u, equal = eq_u, greater = ~less_u & ~eq_u, unord = 0.
  - FP, either input NaN: unord = 1, and less, equal and greater are all 0.
  - FP, both magnitudes zero: equal = 1, so +0 equals -0.
  - FP, signs differ: less = sign_a, greater = ~sign_a.
  - FP, both signs 0: use the magnitude compare, i.e. the unsigned tree result.
  - FP, both signs 1: less and greater are swapped relative to the magnitude compare; equal is unchanged.
- Exactly one of less, equal, greater or unord is 1 whenever o_valid is 1.
- Flow control:
  - S2 may load when S2 is empty or S2 is being consumed (o_valid & i_ready).
  - S1 may load when S1 is empty or S1 is moving into S2.
  - o_ready = ~s1_valid | s1_adv. It is combinational from i_ready; no combinational path exists from i_valid to o_ready.
- Outputs are registered and held stable while o_valid & ~i_ready.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - s1_valid = s2_valid = 0;
  - o_valid = 0;
  - o_less, o_equal, o_greater and o_unord = 0;
  - o_ready = 1 from the first cycle after reset.
- Latency: an input accepted at edge N produces o_valid at edge N+2 when i_ready is held high.
- Throughput: one result per cycle with i_ready = 1.
- Backpressure: with i_ready = 0, the pipe fills two deep, then o_ready = 0. No data is lost or duplicated.
- Simultaneous events: accept-into-S1, S1-to-S2 and S2-consume in the same cycle are all legal when full with i_ready = 1.
- Reset mid-operation: all in-flight transactions are discarded. No output pulse follows deassertion.
- Data-path registers need no reset; valid bits and outputs do.

## Structure
- Package comp_pkg holds:
  - the mode enum comp_mode_e (CMP_UNS, CMP_SGN, CMP_FP, CMP_RSV);
  - a default LEAF_W constant;
  - a result struct comp_res_t {less, equal, greater, unord}.
- Sub-module comp_leaf_nbit (parameter W) produces the less/equal outputs of one leaf. It is instantiated N_LEAF times in a generate loop.
- The S2 reduction is a parametric function or loop, not hand-unrolled.
- Elaboration assertion: DATA_W % LEAF_W == 0 and EXP_W < DATA_W-1.

## Test plan
- Unsigned, DATA_W=32: A=0x8000_0000, B=0x7FFF_FFFF -> greater=1 at edge +2. A=B=0x1234_5678 -> equal=1.
- Signed: A=0x8000_0000, B=0x0000_0001 -> less=1. A=0xFFFF_FFFF, B=0xFFFF_FFFE -> greater=1.
- FP:
  - A=0x8000_0000 (-0), B=0x0000_0000 -> equal=1.
  - A=0xBF80_0000 (-1.0), B=0xC000_0000 (-2.0) -> greater=1.
  - A=0x7FC0_0000 (NaN), B=0x3F80_0000 (1.0) -> unord=1 with the others 0.
- Streaming with random i_ready (~50%) over 1000 random transactions with mixed modes: results match the reference model in order, with none lost or duplicated. o_ready drops only when both stages are full and i_ready=0.
- Hold: i_ready=0 for 5 cycles with the result pending -> o_* remain stable and o_ready=0 after the second accept. On release, two results appear on consecutive cycles.
- Reset mid-stream: assert i_rst_n=0 with both stages valid -> o_valid=0 immediately (asynchronous). After release, o_ready=1 and no stale result appears.

Source files
------------

// File: rtl/comp_pipe_nbit_pkg.sv
// Shared types for the pipelined magnitude comparator: compare mode, result flags
// and the default leaf width.
package comp_pkg;

    localparam int unsigned LEAF_W_DEF = 4;

    typedef enum logic [1:0] {
        CMP_UNS = 2'b00,
        CMP_SGN = 2'b01,
        CMP_FP  = 2'b10,
        CMP_RSV = 2'b11
    } comp_mode_e;

    typedef struct packed {
        logic less;
        logic equal;
        logic greater;
        logic unord;
    } comp_res_t;

endpackage

// File: rtl/comp_pipe_nbit_if.sv
// Operand/result handshake bundle for comp_pipe_nbit; signal names are from the
// comparator's point of view (i_* into the block, o_* out of it).
interface comp_pipe_nbit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data_a;
    logic [DATA_W-1:0] i_data_b;
    logic [1:0]        i_mode;
    logic              o_valid;
    logic              i_ready;
    logic              o_less;
    logic              o_equal;
    logic              o_greater;
    logic              o_unord;

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_mode, i_ready,
        output o_ready, o_valid, o_less, o_equal, o_greater, o_unord
    );

    modport master (
        output i_valid, i_data_a, i_data_b, i_mode, i_ready,
        input  o_ready, o_valid, o_less, o_equal, o_greater, o_unord
    );
endinterface

// File: rtl/comp_pipe_nbit_leaf.sv
// One first-level leaf of the comparator tree: unsigned less/equal of a W-bit slice.
module comp_leaf_nbit #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         less_o,
    output logic         equal_o
);
    assign less_o  = (a_i < b_i);
    assign equal_o = (a_i == b_i);
endmodule

// File: rtl/comp_pipe_nbit.sv
// Two-stage pipelined comparator (unsigned / signed / sign-magnitude FP) with
// valid/ready flow control. S1 holds leaf results and FP flags, S2 the final flags.
module comp_pipe_nbit
    import comp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEAF_W = LEAF_W_DEF,
    parameter int unsigned EXP_W  = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    comp_pipe_nbit_if.slave bus
);
    localparam int unsigned N_LEAF = DATA_W / LEAF_W;
    localparam int unsigned MAN_W  = DATA_W - 1 - EXP_W;

    if ((DATA_W % LEAF_W) != 0 || EXP_W >= DATA_W - 1 || DATA_W < 8) begin : g_bad_cfg
        $fatal(1, "comp_pipe_nbit: illegal DATA_W/LEAF_W/EXP_W combination");
    end

    comp_mode_e        mode_c;
    logic [DATA_W-1:0] op_a_c, op_b_c;
    logic [N_LEAF-1:0] leaf_lt_c, leaf_eq_c;
    logic              nan_a_c, nan_b_c;
    logic              s2_ready_c, s1_adv_c, accept_c;

    logic [N_LEAF-1:0] leaf_lt_q, leaf_eq_q;
    comp_mode_e        mode_q;
    logic              sign_a_q, sign_b_q, zero_a_q, zero_b_q, nan_a_q, nan_b_q;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    comp_res_t         res_q, res_d;
    logic              less_u_c, eq_u_c;

    assign mode_c = comp_mode_e'(bus.i_mode);

    // Flipping both MSBs maps two's-complement order onto unsigned order.
    always_comb begin
        op_a_c = bus.i_data_a;
        op_b_c = bus.i_data_b;
        if (mode_c == CMP_SGN) begin
            op_a_c[DATA_W-1] = ~bus.i_data_a[DATA_W-1];
            op_b_c[DATA_W-1] = ~bus.i_data_b[DATA_W-1];
        end
    end

    for (genvar i = 0; i < N_LEAF; i++) begin : g_leaf
        comp_leaf_nbit #(.W(LEAF_W)) u_leaf (
            .a_i     (op_a_c[i*LEAF_W +: LEAF_W]),
            .b_i     (op_b_c[i*LEAF_W +: LEAF_W]),
            .less_o  (leaf_lt_c[i]),
            .equal_o (leaf_eq_c[i])
        );
    end

    assign nan_a_c = (&bus.i_data_a[DATA_W-2 -: EXP_W]) & (|bus.i_data_a[MAN_W-1:0]);
    assign nan_b_c = (&bus.i_data_b[DATA_W-2 -: EXP_W]) & (|bus.i_data_b[MAN_W-1:0]);

    assign s2_ready_c  = ~s2_valid_q | bus.i_ready;
    assign s1_adv_c    = s1_valid_q & s2_ready_c;
    assign bus.o_ready = ~s1_valid_q | s1_adv_c;
    assign accept_c    = bus.i_valid & bus.o_ready;

    // S1 payload: no reset, qualified by s1_valid_q.
    always_ff @(posedge i_clk) begin
        if (accept_c) begin
            leaf_lt_q <= leaf_lt_c;
            leaf_eq_q <= leaf_eq_c;
            mode_q    <= mode_c;
            sign_a_q  <= bus.i_data_a[DATA_W-1];
            sign_b_q  <= bus.i_data_b[DATA_W-1];
            zero_a_q  <= ~|bus.i_data_a[DATA_W-2:0];
            zero_b_q  <= ~|bus.i_data_b[DATA_W-2:0];
            nan_a_q   <= nan_a_c;
            nan_b_q   <= nan_b_c;
        end
    end

    // Leaf reduction, low to high: less = L_hi | (E_hi & less_lo).
    always_comb begin
        less_u_c = 1'b0;
        eq_u_c   = 1'b1;
        for (int i = 0; i < int'(N_LEAF); i++) begin
            less_u_c = leaf_lt_q[i] | (leaf_eq_q[i] & less_u_c);
            eq_u_c   = eq_u_c & leaf_eq_q[i];
        end
    end

    // Mode resolution; FP with equal signs reuses the magnitude compare.
    always_comb begin
        res_d = '0;
        if (mode_q == CMP_FP) begin
            if (nan_a_q | nan_b_q) begin
                res_d.unord = 1'b1;
            end else if (zero_a_q & zero_b_q) begin
                res_d.equal = 1'b1;
            end else if (sign_a_q != sign_b_q) begin
                res_d.less    = sign_a_q;
                res_d.greater = ~sign_a_q;
            end else begin
                res_d.equal   = eq_u_c;
                res_d.less    = sign_a_q ? (~less_u_c & ~eq_u_c) : less_u_c;
                res_d.greater = sign_a_q ? less_u_c : (~less_u_c & ~eq_u_c);
            end
        end else begin
            res_d.less    = less_u_c;
            res_d.equal   = eq_u_c;
            res_d.greater = ~less_u_c & ~eq_u_c;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (bus.o_ready) s1_valid_d = bus.i_valid;
        if (s2_ready_c)  s2_valid_d = s1_valid_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            res_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_adv_c) res_q <= res_d;
        end
    end

    assign bus.o_valid   = s2_valid_q;
    assign bus.o_less    = res_q.less;
    assign bus.o_equal   = res_q.equal;
    assign bus.o_greater = res_q.greater;
    assign bus.o_unord   = res_q.unord;
endmodule

// File: tb/tb_comp_pipe_nbit.sv
// Self-checking bench for comp_pipe_nbit: directed vectors, random streaming with
// backpressure, hold behaviour and asynchronous reset mid-stream.
module tb_comp_pipe_nbit;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    comp_pipe_nbit_if #(.DATA_W(32)) bus ();

    comp_pipe_nbit #(.DATA_W(32), .LEAF_W(4), .EXP_W(8)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] res_now();
        return {bus.o_less, bus.o_equal, bus.o_greater, bus.o_unord};
    endfunction

    // Reference: {less, equal, greater, unord}; FP ordered via a signed key.
    function automatic logic [3:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] m);
        logic signed [32:0] ka, kb;
        logic               na, nb;
        case (m)
            2'b01: return {$signed(a) < $signed(b), a == b, $signed(a) > $signed(b), 1'b0};
            2'b10: begin
                na = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
                nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
                if (na || nb) return 4'b0001;
                ka = a[31] ? -$signed({2'b00, a[30:0]}) : $signed({2'b00, a[30:0]});
                kb = b[31] ? -$signed({2'b00, b[30:0]}) : $signed({2'b00, b[30:0]});
                return {ka < kb, ka == kb, ka > kb, 1'b0};
            end
            default: return {a < b, a == b, a > b, 1'b0};
        endcase
    endfunction

    task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] m, input logic [3:0] exp);
        @(posedge clk); #1;
        bus.i_valid = 1'b1; bus.i_data_a = a; bus.i_data_b = b; bus.i_mode = m;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        check_eq({tag, "_lat1"}, 32'(bus.o_valid), 32'd0);
        @(posedge clk); #1;
        check_eq({tag, "_vld"}, 32'(bus.o_valid), 32'd1);
        check_eq({tag, "_res"}, 32'(res_now()), 32'(exp));
    endtask

    task automatic gen_op(output logic [31:0] a, output logic [31:0] b, output logic [1:0] m);
        a = $urandom;
        b = $urandom;
        m = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
            0: b = a;
            1: b = a ^ 32'h8000_0000;
            2: begin a = {a[31], 31'h0}; b = {b[31], 31'h0}; end
            3: a = {a[31], 8'hFF, a[22:0] | 23'h1};
            4: b = a ^ 32'($urandom_range(1, 15));
            5: b = {a[31:4], b[3:0]};
            default: ;
        endcase
    endtask

    task automatic fill_two(input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] m1,
                            input logic [31:0] a2, input logic [31:0] b2, input logic [1:0] m2);
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1; bus.i_data_a = a1; bus.i_data_b = b1; bus.i_mode = m1;
        @(posedge clk); #1;
        bus.i_data_a = a2; bus.i_data_b = b2; bus.i_mode = m2;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
    endtask

    localparam int N_STREAM = 1000;

    initial begin
        logic [3:0]  exp_q[$];
        logic [3:0]  e;
        logic [31:0] ra, rb;
        logic [1:0]  rm;
        int          sent, got, cyc;
        bit          advance;

        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_data_a = '0; bus.i_data_b = '0;
        bus.i_mode = 2'b00; bus.i_ready = 1'b0;
        #12;
        check_eq("rst_valid", 32'(bus.o_valid), 32'd0);
        check_eq("rst_res", 32'(res_now()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ready", 32'(bus.o_ready), 32'd1);

        run_vec("uns_gt",     32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 4'b0010);
        run_vec("uns_eq",     32'h1234_5678, 32'h1234_5678, 2'b00, 4'b0100);
        run_vec("uns_leaf",   32'h0000_0010, 32'h0000_000F, 2'b00, 4'b0010);
        run_vec("uns_lt",     32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 4'b1000);
        run_vec("rsv_lt",     32'h0000_0001, 32'h0000_0002, 2'b11, 4'b1000);
        run_vec("sgn_lt",     32'h8000_0000, 32'h0000_0001, 2'b01, 4'b1000);
        run_vec("sgn_gt",     32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b01, 4'b0010);
        run_vec("sgn_gt0",    32'h0000_0000, 32'hFFFF_FFFF, 2'b01, 4'b0010);
        run_vec("fp_zero",    32'h8000_0000, 32'h0000_0000, 2'b10, 4'b0100);
        run_vec("fp_negneg",  32'hBF80_0000, 32'hC000_0000, 2'b10, 4'b0010);
        run_vec("fp_nan",     32'h7FC0_0000, 32'h3F80_0000, 2'b10, 4'b0001);
        run_vec("fp_nanneg",  32'hFF80_0001, 32'h0000_0000, 2'b10, 4'b0001);
        run_vec("fp_sgndiff", 32'h3F80_0000, 32'hBF80_0000, 2'b10, 4'b0010);
        run_vec("fp_inf_eq",  32'h7F80_0000, 32'h7F80_0000, 2'b10, 4'b0100);
        run_vec("fp_denorm",  32'h0000_0001, 32'h0000_0000, 2'b10, 4'b0010);
        run_vec("fp_pos_lt",  32'h3F80_0000, 32'h4000_0000, 2'b10, 4'b1000);

        // Hold: two results pending, downstream stalled.
        fill_two(32'hBF80_0000, 32'h3F80_0000, 2'b10, 32'h0000_0005, 32'h0000_0003, 2'b00);
        check_eq("hold_ready", 32'(bus.o_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_vld", 32'(bus.o_valid), 32'd1);
            check_eq("hold_res", 32'(res_now()), 32'b1000);
            check_eq("hold_rdy", 32'(bus.o_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        @(negedge clk);
        check_eq("rel_first_vld", 32'(bus.o_valid), 32'd1);
        check_eq("rel_first_res", 32'(res_now()), 32'b1000);
        @(posedge clk); #1;
        check_eq("rel_second_vld", 32'(bus.o_valid), 32'd1);
        check_eq("rel_second_res", 32'(res_now()), 32'b0010);
        @(posedge clk); #1;
        check_eq("rel_empty", 32'(bus.o_valid), 32'd0);

        // Streaming with random backpressure against the reference model.
        sent = 0; got = 0; cyc = 0;
        @(posedge clk); #1;
        gen_op(ra, rb, rm);
        bus.i_valid = 1'b1; bus.i_data_a = ra; bus.i_data_b = rb; bus.i_mode = rm;
        bus.i_ready = 1'($urandom_range(0, 1));
        while (got < N_STREAM && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (bus.o_valid && bus.i_ready) begin
                check_eq("stream_nodup", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("stream_res", 32'(res_now()), 32'(e));
                    got++;
                end
            end
            advance = 1'b0;
            if (bus.i_valid && bus.o_ready) begin
                exp_q.push_back(ref_cmp(bus.i_data_a, bus.i_data_b, bus.i_mode));
                sent++;
                advance = 1'b1;
            end
            if (!bus.o_ready)
                check_eq("stream_ready_drop", 32'({bus.o_valid, bus.i_ready}), 32'b10);
            @(posedge clk); #1;
            if (sent < N_STREAM && (advance || !bus.i_valid)) begin
                bus.i_valid = ($urandom_range(0, 7) != 0);
                gen_op(ra, rb, rm);
                bus.i_data_a = ra; bus.i_data_b = rb; bus.i_mode = rm;
            end else if (sent >= N_STREAM) begin
                bus.i_valid = 1'b0;
            end
            bus.i_ready = 1'($urandom_range(0, 1));
        end
        check_eq("stream_count", 32'(got), 32'(N_STREAM));
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stream_drained", 32'(bus.o_valid), 32'd0);
        end
        check_eq("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with both stages occupied.
        fill_two(32'h0000_0001, 32'h0000_0002, 2'b00, 32'h0000_0009, 32'h0000_0002, 2'b00);
        check_eq("prerst_vld", 32'(bus.o_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_vld", 32'(bus.o_valid), 32'd0);
        check_eq("async_rst_res", 32'(res_now()), 32'd0);
        bus.i_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("postrst_ready", 32'(bus.o_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("postrst_no_stale", 32'(bus.o_valid), 32'd0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
